// File: rtl/shift_ram_sweep.sv
// RAM-backed delay line for the correlator front end: each accepted sample is
// stored in a circular RAM, and the full history is then swept out newest-first.
module shift_ram_sweep #(
    parameter int DW = 8,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [DW-1:0] din,
    input  logic          sin,
    output logic [DW-1:0] dout,
    output logic          sout,
    output logic [DW-1:0] dshift,
    output logic          dshift_valid,
    output logic [AW-1:0] lag,
    output logic          first,
    output logic          last,
    output logic          busy,
    output logic          overrun
);

    localparam int unsigned   DEPTH    = 2 ** AW;
    localparam logic [AW-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN,
        CLEAR
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] wp, wp_nxt;
    logic [AW-1:0] base, base_nxt;
    // Shared counter: read lag while sweeping, clear address while clearing.
    logic [AW-1:0] cnt, cnt_nxt;

    logic          accept;
    logic          drop;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] ram_q;
    logic          out_valid;
    logic [AW-1:0] out_lag;

    always_comb begin
        state_nxt = state;
        wp_nxt    = wp;
        base_nxt  = base;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = wp;
        mem_wdata = din;
        rd_en     = 1'b0;
        rd_addr   = base - cnt;

        case (state)
            IDLE: begin
                if (clr) begin
                    state_nxt = CLEAR;
                    wp_nxt    = '0;
                    cnt_nxt   = '0;
                end else if (sin) begin
                    accept    = 1'b1;
                    mem_we    = 1'b1;
                    base_nxt  = wp;
                    wp_nxt    = wp + 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = SWEEP;
                end
            end
            SWEEP: begin
                if (clr) begin
                    state_nxt = CLEAR;
                    wp_nxt    = '0;
                    cnt_nxt   = '0;
                end else begin
                    rd_en   = 1'b1;
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == LAST_IDX) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (clr) begin
                    state_nxt = CLEAR;
                    wp_nxt    = '0;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt;
                mem_wdata = '0;
                cnt_nxt   = cnt + 1'b1;
                if (cnt == LAST_IDX) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A strobe is lost when the block is busy, or when clr wins in IDLE.
    assign drop = sin && ((state != IDLE) || clr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wp        <= '0;
            base      <= '0;
            cnt       <= '0;
            dout      <= '0;
            sout      <= 1'b0;
            overrun   <= 1'b0;
            out_valid <= 1'b0;
            out_lag   <= '0;
        end else begin
            state     <= state_nxt;
            wp        <= wp_nxt;
            base      <= base_nxt;
            cnt       <= cnt_nxt;
            sout      <= accept;
            overrun   <= drop;
            out_valid <= rd_en;
            if (accept) begin
                dout <= din;
            end
            if (rd_en) begin
                out_lag <= cnt;
            end
        end
    end

    // RAM contents are deliberately not reset so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (rd_en) begin
            ram_q <= mem[rd_addr];
        end
    end

    assign busy         = (state != IDLE);
    assign dshift_valid = out_valid;
    assign dshift       = out_valid ? ram_q : '0;
    assign lag          = out_valid ? out_lag : '0;
    assign first        = out_valid && (out_lag == '0);
    assign last         = out_valid && (out_lag == LAST_IDX);

endmodule
